// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch address and selects the next PC by fixed redirect priority.
// Define PC_RAS_EN to build the circular return-address stack used by Call/Return.
module pc_sequencer #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] PC_LIMIT     = WIDTH'(220),
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(4),
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WriteEnable,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Return,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus,
    output logic             OutOfRange,
    output logic             RasEmpty,
    output logic             RasError
);

    logic [WIDTH-1:0] pc_q;
    logic             hold_q;
    logic             oor_q;
    logic             update;
    logic [WIDTH-1:0] sel_next;
    logic             oor_d;
    logic [WIDTH-1:0] pc_d;

    assign PCPlus     = pc_q + STEP;
    assign PC         = pc_q;
    assign OutOfRange = oor_q;

    // The hold cycle and stalls both block any architectural change.
    assign update = !hold_q && WriteEnable;

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    sp_q;
    logic [PW:0]      count_q;
    logic [PW-1:0]    top_idx;
    logic             ras_empty;
    logic             rerr_q;
    logic             ras_err_d;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    assign top_idx   = sp_q - 1'b1;
    assign ras_empty = (count_q == '0);
    assign RasEmpty  = ras_empty;
    assign RasError  = rerr_q;

    always_comb begin
        sel_next  = PCPlus;
        ras_err_d = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_swap   = 1'b0;
        if (Return && !ras_empty) begin
            sel_next = ras_mem[top_idx];
            if (Call) begin
                do_swap = 1'b1;
            end else begin
                do_pop = 1'b1;
            end
        end else if (Return) begin
            sel_next  = PCPlus;
            ras_err_d = 1'b1;
        end else if (Call) begin
            sel_next = JumpTarget;
            do_push  = 1'b1;
        end else if (Jump) begin
            sel_next = JumpTarget;
        end else if (BranchTaken) begin
            sel_next = BranchTarget;
        end
    end

    // sp points at the next free slot; when full it points at the oldest entry,
    // so a push naturally overwrites it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (update) begin
            if (do_push) begin
                ras_mem[sp_q] <= PCPlus;
                sp_q          <= sp_q + 1'b1;
                if (count_q != DEPTH_C) begin
                    count_q <= count_q + 1'b1;
                end
            end else if (do_pop) begin
                sp_q    <= top_idx;
                count_q <= count_q - 1'b1;
            end else if (do_swap) begin
                ras_mem[top_idx] <= PCPlus;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rerr_q <= 1'b0;
        end else if (update) begin
            rerr_q <= ras_err_d;
        end else begin
            rerr_q <= 1'b0;
        end
    end
`else
    logic ret_unused;

    assign ret_unused = Return;
    assign RasEmpty   = 1'b1;
    assign RasError   = 1'b0;

    // Without a stack a call is just a jump and a return carries no meaning.
    always_comb begin
        sel_next = PCPlus;
        if (Call || Jump) begin
            sel_next = JumpTarget;
        end else if (BranchTaken) begin
            sel_next = BranchTarget;
        end
    end
`endif

    assign oor_d = (sel_next > PC_LIMIT);
    assign pc_d  = oor_d ? RESET_VECTOR : sel_next;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q   <= RESET_VECTOR;
            hold_q <= 1'b1;
            oor_q  <= 1'b0;
        end else if (hold_q) begin
            hold_q <= 1'b0;
            oor_q  <= 1'b0;
        end else if (WriteEnable) begin
            pc_q  <= pc_d;
            oor_q <= oor_d;
        end else begin
            oor_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters; RAS checks build when PC_RAS_EN is defined.
module tb_pc_sequencer;

    logic        Clock;
    logic        Reset;
    logic        WriteEnable;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic        Call;
    logic        Return;
    logic [31:0] JumpTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus;
    logic        OutOfRange;
    logic        RasEmpty;
    logic        RasError;

    int vectors;
    int miscompares;

    pc_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .WriteEnable  (WriteEnable),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .Call         (Call),
        .Return       (Return),
        .JumpTarget   (JumpTarget),
        .PC           (PC),
        .PCPlus       (PCPlus),
        .OutOfRange   (OutOfRange),
        .RasEmpty     (RasEmpty),
        .RasError     (RasError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        BranchTaken  = 1'b0;
        Jump         = 1'b0;
        Call         = 1'b0;
        Return       = 1'b0;
        BranchTarget = '0;
        JumpTarget   = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b0;
        WriteEnable = 1'b1;
        idle();
        #12;
        check("reset_pc", PC, 32'd0);
        check("reset_pcplus", PCPlus, 32'd4);
        check("reset_oor", {31'd0, OutOfRange}, 32'd0);
        check("reset_raserr", {31'd0, RasError}, 32'd0);
        check("reset_rasempty", {31'd0, RasEmpty}, 32'd1);
        #11 Reset = 1'b1;

        step(); check("hold_pc", PC, 32'd0);
        step(); check("seq1_pc", PC, 32'd4);
        step(); check("seq2_pc", PC, 32'd8);
        step(); check("seq3_pc", PC, 32'd12);
        step(); check("seq4_pc", PC, 32'd16);

        // Jump beats branch.
        Jump = 1'b1; BranchTaken = 1'b1; JumpTarget = 32'd40; BranchTarget = 32'd80;
        step(); check("jump_prio_pc", PC, 32'd40);
        idle(); WriteEnable = 1'b0;
        step(); check("stall_pc", PC, 32'd40);
        check("stall_pcplus", PCPlus, 32'd44);
        WriteEnable = 1'b1;

        // Range guard at the limit.
        BranchTaken = 1'b1; BranchTarget = 32'd216;
        step(); check("branch_pc", PC, 32'd216);
        idle();
        step(); check("limit_pc", PC, 32'd220);
        check("limit_oor", {31'd0, OutOfRange}, 32'd0);
        step(); check("over_pc", PC, 32'd0);
        check("over_oor", {31'd0, OutOfRange}, 32'd1);
        step(); check("after_over_pc", PC, 32'd4);
        check("oor_pulse_clear", {31'd0, OutOfRange}, 32'd0);
        BranchTaken = 1'b1; BranchTarget = 32'd224;
        step(); check("bt_over_pc", PC, 32'd0);
        check("bt_over_oor", {31'd0, OutOfRange}, 32'd1);
        idle(); WriteEnable = 1'b0;
        step(); check("stall_oor_clear", {31'd0, OutOfRange}, 32'd0);
        check("stall_pc_zero", PC, 32'd0);
        WriteEnable = 1'b1;

`ifdef PC_RAS_EN
        BranchTaken = 1'b1; BranchTarget = 32'd8;
        step(); check("ras_setup_pc", PC, 32'd8);
        idle(); Call = 1'b1;
        JumpTarget = 32'd100; step(); check("call1_pc", PC, 32'd100);
        check("call1_notempty", {31'd0, RasEmpty}, 32'd0);
        JumpTarget = 32'd104; step(); check("call2_pc", PC, 32'd104);
        JumpTarget = 32'd108; step(); check("call3_pc", PC, 32'd108);
        JumpTarget = 32'd112; step(); check("call4_pc", PC, 32'd112);
        JumpTarget = 32'd116; step(); check("call5_pc", PC, 32'd116);
        idle(); Return = 1'b1;
        step(); check("ret1_pc", PC, 32'd116);
        step(); check("ret2_pc", PC, 32'd112);
        step(); check("ret3_pc", PC, 32'd108);
        step(); check("ret4_pc", PC, 32'd104);
        check("ret4_empty", {31'd0, RasEmpty}, 32'd1);
        check("ret4_noerr", {31'd0, RasError}, 32'd0);
        step(); check("ret5_pc", PC, 32'd108);
        check("ret5_raserr", {31'd0, RasError}, 32'd1);
        idle();
        step(); check("raserr_clear", {31'd0, RasError}, 32'd0);
        check("after_err_pc", PC, 32'd112);

        // Call and Return together swap the top entry.
        BranchTaken = 1'b1; BranchTarget = 32'd48;
        step(); check("cr_setup_pc", PC, 32'd48);
        idle(); Call = 1'b1; JumpTarget = 32'd20;
        step(); check("cr_call_pc", PC, 32'd20);
        Return = 1'b1; JumpTarget = 32'd60;
        step(); check("cr_swap_pc", PC, 32'd52);
        check("cr_swap_notempty", {31'd0, RasEmpty}, 32'd0);
        idle(); WriteEnable = 1'b0; Return = 1'b1;
        step(); check("stall_ret_pc", PC, 32'd52);
        check("stall_ret_notempty", {31'd0, RasEmpty}, 32'd0);
        WriteEnable = 1'b1;
        step(); check("cr_ret_pc", PC, 32'd24);
        check("cr_ret_empty", {31'd0, RasEmpty}, 32'd1);

        // Populate the stack before the asynchronous reset.
        idle(); Call = 1'b1; JumpTarget = 32'd40;
        step(); check("pre_reset_pc", PC, 32'd40);
        check("pre_reset_notempty", {31'd0, RasEmpty}, 32'd0);
`else
        Call = 1'b1; JumpTarget = 32'd60;
        step(); check("call_as_jump_pc", PC, 32'd60);
        check("noras_empty", {31'd0, RasEmpty}, 32'd1);
        idle(); Return = 1'b1;
        step(); check("ret_ignored_pc", PC, 32'd64);
        check("noras_noerr", {31'd0, RasError}, 32'd0);
        BranchTaken = 1'b1; BranchTarget = 32'd100;
        step(); check("ret_fallthru_pc", PC, 32'd100);
        idle(); Jump = 1'b1; JumpTarget = 32'd40;
        step(); check("pre_reset_pc", PC, 32'd40);
`endif

        idle();
        #2 Reset = 1'b0;
        #1;
        check("async_reset_pc", PC, 32'd0);
        check("async_reset_empty", {31'd0, RasEmpty}, 32'd1);
        check("async_reset_oor", {31'd0, OutOfRange}, 32'd0);
        #3 Reset = 1'b1;
        step(); check("rehold_pc", PC, 32'd0);
        step(); check("post_reset_seq_pc", PC, 32'd4);
        Return = 1'b1;
        step(); check("post_reset_ret_pc", PC, 32'd8);
`ifdef PC_RAS_EN
        check("post_reset_raserr", {31'd0, RasError}, 32'd1);
`else
        check("post_reset_raserr", {31'd0, RasError}, 32'd0);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle/pipelined datapath. It replaces the fixed 32-bit PC register and takes over next-PC selection. It holds the fetch address, advances it by a configurable step, and applies branch, jump, call and return redirects by fixed priority. It also inserts one hold cycle after reset and forces out-of-range targets back to the reset vector. An optional return-address stack is compiled in with a macro.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits
- RESET_VECTOR, 0, PC value after reset and after an out-of-range redirect
- PC_LIMIT, 220, highest legal PC value; any next PC > PC_LIMIT is out of range
- STEP, 4, sequential increment
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2; used only with PC_RAS_EN)

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous active-low reset
- WriteEnable  input  1  1 = update PC this cycle; 0 = stall (PC and stack frozen)
- BranchTaken  input  1  take BranchTarget
- BranchTarget  input  WIDTH  conditional branch destination
- Jump  input  1  take JumpTarget
- Call  input  1  jump to JumpTarget and push PC+STEP
- Return  input  1  redirect to top of return stack and pop
- JumpTarget  input  WIDTH  jump/call destination
- PC  output  WIDTH  current fetch address (registered)
- PCPlus  output  WIDTH  PC+STEP (combinational, mod 2^WIDTH)
- OutOfRange  output  1  registered one-cycle pulse: last update was forced to RESET_VECTOR
- RasEmpty  output  1  return stack holds zero entries
- RasError  output  1  registered one-cycle pulse: Return issued with empty stack

## Operation
- Reset low (async): PC=RESET_VECTOR, hold flag=1, OutOfRange=0, RasError=0, stack count=0, RasEmpty=1.
- Per rising edge, in priority order:
  1. Hold flag set: clear hold; PC unchanged; no stack change; WriteEnable ignored.
  2. WriteEnable=0: everything frozen; pulses clear to 0.
  3. Return (stack non-empty): next = top; pop. With Call also asserted: next = top, top overwritten with PCPlus, count unchanged.
  4. Return (stack empty): next = PCPlus; RasError=1; no pop.
  5. Call: next = JumpTarget; push PCPlus.
  6. Jump: next = JumpTarget.
  7. BranchTaken: next = BranchTarget.
  8. Otherwise next = PCPlus.
- Range guard (after selection, unsigned compare): next > PC_LIMIT → PC=RESET_VECTOR, OutOfRange=1. Otherwise PC=next, OutOfRange=0. A push or pop in the same cycle still takes effect.
- PCPlus wraps mod 2^WIDTH. A wrapped value is range-checked normally.
- Stack is circular. A push when count==RAS_DEPTH overwrites the oldest entry and count stays saturated. A pop decrements count.

## Timing
- PC changes one edge after the selecting inputs; PCPlus follows PC combinationally.
- The first active edge after Reset deasserts is always the hold cycle. The first PC update is on the second edge.
- OutOfRange and RasError are valid in the cycle following the causing edge, for exactly one cycle.
- Reset asserted mid-stall or mid-redirect aborts immediately and discards stack contents.
- Inputs must be stable setup-before each edge. No combinational path from inputs to PC.

## Configuration
- PC_RAS_EN defined: return stack built with RAS_DEPTH entries, behaviour as above.
- PC_RAS_EN undefined: no storage. Call behaves as Jump. Return is ignored and falls through to lower priorities. RasEmpty is tied 1 and RasError tied 0.

## Test plan
- Reset low, then release; apply WriteEnable=1 → PC=0 after the first edge (hold), PC=4 after the second, PC=8 after the third.
- PC=16, Jump=1 and BranchTaken=1 with JumpTarget=40 and BranchTarget=80 → PC=40. With WriteEnable=0 on the next cycle → PC stays 40.
- PC=216, sequential → PC=220, OutOfRange=0. Next edge → PC=0, OutOfRange=1 for one cycle. BranchTarget=224 taken → PC=0, OutOfRange=1.
- PC_RAS_EN, RAS_DEPTH=4: five Calls from PC=8,100,104,108,112 (targets in range) then five Returns → returns to 116,112,108,104, then RasError=1 on the fifth with PC=current+4.
- PC_RAS_EN, Call+Return together with top=52, PC=20, JumpTarget=60 → PC=52, top becomes 24, count unchanged.
- Reset asserted asynchronously between edges during stack use → PC=0 immediately, RasEmpty=1, and the hold cycle repeats after release.
